config_stream_deframer: RTL and testbench
=========================================

Name: config_stream_deframer

Overview:
- Parametrised successor of the USB-CDC configuration byte-to-word assembler.
- Consumes the CDC receive byte stream and hunts for a sync pattern.
- Decodes a command byte (target channel) and a length byte, then packs payload bytes MSB-first into words. Words go out on a valid/ready interface with channel tag and last flag.
- Returns one status byte per frame on the CDC transmit path, backpressures the byte stream when the word output stalls, and aborts stalled frames on an inter-byte timeout.

Parameters:
- WORD_BYTES, 4: bytes per output word; output width is 8*WORD_BYTES; legal range ≥1.
- SYNC_BYTES, 3: number of sync bytes; legal range ≥1.
- SYNC_PATTERN, 24'h00AAFF: sync value, width 8*SYNC_BYTES; first received byte lands in the MSBs.
- NUM_CHANNELS, 2: number of valid command codes, 1..NUM_CHANNELS; legal range 1..127.
- TIMEOUT_CYCLES, 65535: idle cycles tolerated between bytes inside a frame; 0 disables the timeout.
- ACK_CODE, 8'hA5: status byte for a good frame.
- ERR_CMD_CODE, 8'hE1: status byte for a bad command.
- ERR_TIMEOUT_CODE, 8'hE2: status byte for a timeout.

Ports:
- clk_i, in, 1: clock.
- reset_i, in, 1: synchronous, active-high reset.
- out_data_i, in, 8: byte from host (CDC OUT endpoint).
- out_valid_i, in, 1: byte valid.
- out_ready_o, out, 1: byte accepted when out_valid_i && out_ready_o.
- in_data_o, out, 8: status byte to host (CDC IN endpoint).
- in_valid_o, out, 1: status byte valid.
- in_ready_i, in, 1: status byte consumed when in_valid_o && in_ready_i.
- word_data_o, out, 8*WORD_BYTES: assembled word.
- word_channel_o, out, 7: target channel, 0-based (command − 1).
- word_last_o, out, 1: last word of frame.
- word_valid_o, out, 1: word valid.
- word_ready_i, in, 1: word consumed when word_valid_o && word_ready_i.
- config_active_o, out, 1: sticky; set on first valid command.

Behaviour:
- Reset (synchronous, any state, mid-frame included):
  - state=HUNT; sync window, assembler, byte and word counters, timeout counter all cleared.
  - All outputs low; data outputs 0. Any partially assembled word is discarded.
- Byte accept is b = out_valid_i && out_ready_o. out_ready_o is 1 except:
  - in RESP: 0;
  - in PAYLOAD: 0 when the output register holds an unconsumed word and the assembler holds WORD_BYTES−1 bytes.
- HUNT:
  - Each accepted byte shifts into the sync window (left shift, new byte in the LSBs).
  - When the window after the shift equals SYNC_PATTERN: go to CMD, next cycle.
  - Overlapping patterns are detected; the window is cleared on entry to HUNT.
- CMD:
  - Accepted byte c with 1 ≤ c ≤ NUM_CHANNELS: channel register = c−1, set config_active_o, go to LEN.
  - Otherwise: status = ERR_CMD_CODE, go to RESP.
- LEN:
  - Accepted byte n sets the word count to n, with n=0 meaning 256 words; go to PAYLOAD.
- PAYLOAD:
  - Bytes fill the assembler MSB-first: the first byte lands in bits [8*WORD_BYTES−1 -: 8].
  - On the WORD_BYTES-th byte, the completed word plus channel and last flag load the output register in the same edge; word_valid_o rises the following cycle, so latency is 1 cycle from the accept of the final byte.
  - Last flag = (remaining words == 1).
  - After the last word is loaded: status = ACK_CODE, go to RESP.
- Output register:
  - word_valid_o holds with stable data until word_ready_i.
  - A load and a consume in the same cycle is legal: the new word replaces the old one and word_valid_o stays 1.
- RESP:
  - in_valid_o=1 with in_data_o = status; held stable until in_ready_i, then go to HUNT.
  - An ACK may be presented while the last word is still pending downstream.
- Timeout (CMD, LEN, PAYLOAD, only when TIMEOUT_CYCLES > 0):
  - The counter resets on every accepted byte and increments otherwise.
  - On reaching TIMEOUT_CYCLES: discard the partial word, status = ERR_TIMEOUT_CODE, go to RESP.
  - A byte accept in the same cycle as the timeout wins and resets the counter.
  - A word already in the output register is kept.
  - Cycles with out_ready_o=0 caused by backpressure do not count.
- Counters: byte index width clog2(WORD_BYTES) (minimum 1); word counter 9 bits; no wrap beyond the programmed length.

Decomposition:
- Shared package config_stream_pkg:
  - state enum (HUNT, CMD, LEN, PAYLOAD, RESP);
  - default status codes;
  - sync default;
  - clog2-derived width constants.
- One natural sub-module, config_word_packer: byte-to-word assembler plus the single-entry output register with valid/ready. It is reusable by other byte-to-word paths. The FSM, sync window and timeout stay in the top.

Test Plan:
- Good frame, no stalls: reset, then bytes 00 AA FF 01 02 DE AD BE EF 01 23 45 67 with word_ready_i=1 → words 0xDEADBEEF (ch0, last=0) and 0x01234567 (ch0, last=1); then in_data_o=0xA5; config_active_o=1.
- Bad command: 00 AA FF 05 → in_valid_o with 0xE1, no word output, back to HUNT; a following good frame on command 02 produces words on ch1.
- Downstream stall: frame with 3 words, word_ready_i=0 → out_ready_o drops after 7 payload bytes; releasing word_ready_i delivers all words in order with no byte loss.
- Timeout: TIMEOUT_CYCLES=16, send header, len 01, then 2 payload bytes and idle → after 16 idle cycles status 0xE2, no word output, return to HUNT.
- Overlap and noise: AA 00 AA FF 02 01 11 22 33 44 → sync is found despite the leading noise; word 0x11223344 on ch1, last=1.
- Mid-frame reset: assert reset_i after 2 payload bytes → next cycle all outputs 0, state HUNT; a subsequent full frame decodes correctly.

Source files
------------

// File: rtl/config_stream_pkg.sv
// Shared types and constants for the configuration stream deframer.
package config_stream_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    CMD     = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [7:0]  ACK_DEFAULT         = 8'hA5;
  localparam logic [7:0]  ERR_CMD_DEFAULT     = 8'hE1;
  localparam logic [7:0]  ERR_TIMEOUT_DEFAULT = 8'hE2;
  localparam int          SYNC_BYTES_DEFAULT  = 3;
  localparam logic [23:0] SYNC_DEFAULT        = 24'h00AAFF;

  localparam int CHAN_W = 7;  // channel tag width
  localparam int WCNT_W = 9;  // word counter, holds 1..256

  // Byte-index width inside a word; never narrower than one bit.
  function automatic int idx_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/config_word_packer.sv
// Byte-to-word assembler (MSB-first) feeding a single-entry valid/ready
// output register.
module config_word_packer
  import config_stream_pkg::*;
#(
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [7:0]              byte_i,
  input  logic                    byte_en_i,
  input  logic                    flush_i,
  input  logic [CHAN_W-1:0]       channel_i,
  input  logic                    last_i,
  output logic                    load_o,
  output logic                    stall_o,
  output logic [8*WORD_BYTES-1:0] word_data_o,
  output logic [CHAN_W-1:0]       word_channel_o,
  output logic                    word_last_o,
  output logic                    word_valid_o,
  input  logic                    word_ready_i
);

  localparam int W    = 8 * WORD_BYTES;
  localparam int IDXW = idx_width(WORD_BYTES);

  logic [W-1:0]        r_asm;
  logic [IDXW-1:0]     r_idx;
  logic [W-1:0]        r_data;
  logic [CHAN_W-1:0]   r_chan;
  logic                r_last;
  logic                r_valid;
  logic                w_idx_full;
  logic [W-1:0]        w_asm_next;

  // Shifting left keeps the first byte of the word in the MSBs.
  assign w_asm_next = (r_asm << 8) | W'(byte_i);
  assign w_idx_full = (r_idx == IDXW'(WORD_BYTES - 1));
  assign load_o     = byte_en_i && w_idx_full;
  // Only the word-completing byte must wait for a free output register.
  assign stall_o    = r_valid && !word_ready_i && w_idx_full;

  // Assembler: collects bytes, empties when a word completes or on flush.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      r_asm <= '0;
      r_idx <= '0;
    end else if (byte_en_i) begin
      if (w_idx_full) begin
        r_asm <= '0;
        r_idx <= '0;
      end else begin
        r_asm <= w_asm_next;
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Output register: load wins over consume so back-to-back words stream.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_data  <= '0;
      r_chan  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (load_o) begin
      r_data  <= w_asm_next;
      r_chan  <= channel_i;
      r_last  <= last_i;
      r_valid <= 1'b1;
    end else if (word_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign word_data_o    = r_data;
  assign word_channel_o = r_chan;
  assign word_last_o    = r_last;
  assign word_valid_o   = r_valid;

endmodule

// File: rtl/config_stream_deframer.sv
// Sync hunt, command/length decode, payload packing and per-frame status
// for the CDC configuration byte stream.
module config_stream_deframer
  import config_stream_pkg::*;
#(
  parameter int                        WORD_BYTES       = 4,
  parameter int                        SYNC_BYTES       = SYNC_BYTES_DEFAULT,
  parameter logic [8*SYNC_BYTES-1:0]   SYNC_PATTERN     = SYNC_DEFAULT,
  parameter int                        NUM_CHANNELS     = 2,
  parameter int                        TIMEOUT_CYCLES   = 65535,
  parameter logic [7:0]                ACK_CODE         = ACK_DEFAULT,
  parameter logic [7:0]                ERR_CMD_CODE     = ERR_CMD_DEFAULT,
  parameter logic [7:0]                ERR_TIMEOUT_CODE = ERR_TIMEOUT_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [7:0]              out_data_i,
  input  logic                    out_valid_i,
  output logic                    out_ready_o,
  output logic [7:0]              in_data_o,
  output logic                    in_valid_o,
  input  logic                    in_ready_i,
  output logic [8*WORD_BYTES-1:0] word_data_o,
  output logic [CHAN_W-1:0]       word_channel_o,
  output logic                    word_last_o,
  output logic                    word_valid_o,
  input  logic                    word_ready_i,
  output logic                    config_active_o
);

  localparam int SW = 8 * SYNC_BYTES;

  state_t              r_state, w_state_nxt;
  logic [SW-1:0]       r_sync;
  logic [CHAN_W-1:0]   r_chan;
  logic [WCNT_W-1:0]   r_words;
  logic [7:0]          r_status;
  logic [31:0]         r_tmo;
  logic                r_active;

  logic [SW-1:0]       w_sync_shift;
  logic                w_accept, w_in_frame, w_cmd_ok, w_bp, w_tmo_hit;
  logic                w_pk_load, w_pk_stall, w_last_word;

  assign w_sync_shift = (r_sync << 8) | SW'(out_data_i);
  assign w_cmd_ok     = (out_data_i != 8'd0) && (out_data_i <= 8'(NUM_CHANNELS));
  assign w_in_frame   = (r_state == CMD) || (r_state == LEN) || (r_state == PAYLOAD);
  assign w_bp         = (r_state == PAYLOAD) && w_pk_stall;
  assign w_last_word  = (r_words == WCNT_W'(1));
  assign out_ready_o  = !reset_i && (r_state != RESP) && !w_bp;
  assign w_accept     = out_valid_i && out_ready_o;
  // A byte arriving on the expiry cycle keeps the frame alive.
  assign w_tmo_hit    = (TIMEOUT_CYCLES > 0) && w_in_frame && !w_accept && !w_bp &&
                        (r_tmo == 32'(TIMEOUT_CYCLES - 1));
  assign config_active_o = r_active;

  config_word_packer #(.WORD_BYTES(WORD_BYTES)) u_packer (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .byte_i         (out_data_i),
    .byte_en_i      (w_accept && (r_state == PAYLOAD)),
    .flush_i        (w_tmo_hit),
    .channel_i      (r_chan),
    .last_i         (w_last_word),
    .load_o         (w_pk_load),
    .stall_o        (w_pk_stall),
    .word_data_o    (word_data_o),
    .word_channel_o (word_channel_o),
    .word_last_o    (word_last_o),
    .word_valid_o   (word_valid_o),
    .word_ready_i   (word_ready_i)
  );

  // Frame state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= HUNT;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode and status-port drive.
  always_comb begin
    w_state_nxt = r_state;
    in_valid_o  = 1'b0;
    in_data_o   = 8'd0;
    case (r_state)
      HUNT:    if (w_accept && (w_sync_shift == SYNC_PATTERN)) w_state_nxt = CMD;
      CMD:     if (w_accept) w_state_nxt = w_cmd_ok ? LEN : RESP;
      LEN:     if (w_accept) w_state_nxt = PAYLOAD;
      PAYLOAD: if (w_pk_load && w_last_word) w_state_nxt = RESP;
      RESP: begin
        in_valid_o = 1'b1;
        in_data_o  = r_status;
        if (in_ready_i) w_state_nxt = HUNT;
      end
      default: w_state_nxt = HUNT;
    endcase
    if (w_tmo_hit) w_state_nxt = RESP;
  end

  // Frame datapath: sync window, channel, word count, status, timeout.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sync   <= '0;
      r_chan   <= '0;
      r_words  <= '0;
      r_status <= 8'd0;
      r_tmo    <= '0;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        HUNT: if (w_accept) r_sync <= w_sync_shift;
        CMD: if (w_accept) begin
          if (w_cmd_ok) begin
            r_chan   <= CHAN_W'(out_data_i - 8'd1);
            r_active <= 1'b1;
          end else begin
            r_status <= ERR_CMD_CODE;
          end
        end
        LEN: if (w_accept) r_words <= (out_data_i == 8'd0) ? WCNT_W'(256) : WCNT_W'(out_data_i);
        PAYLOAD: if (w_pk_load) begin
          if (w_last_word) r_status <= ACK_CODE;
          else             r_words  <= r_words - 1'b1;
        end
        RESP: if (in_ready_i) r_sync <= '0;  // fresh window on HUNT entry
        default: ;
      endcase
      if (!w_in_frame || w_accept || w_tmo_hit) r_tmo <= '0;
      else if (!w_bp)                           r_tmo <= r_tmo + 1'b1;
      if (w_tmo_hit) r_status <= ERR_TIMEOUT_CODE;
    end
  end

endmodule

// File: tb/tb_config_stream_deframer.sv
// Randomised scoreboard bench for config_stream_deframer.
module tb_config_stream_deframer;

  localparam int WB  = 4;
  localparam int TMO = 16;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [8*WB-1:0] d;
    logic [6:0]      ch;
    logic            last;
  } wexp_t;

  logic            clk_i = 1'b0;
  logic            reset_i = 1'b1;
  logic [7:0]      out_data_i = 8'd0;
  logic            out_valid_i = 1'b0;
  logic            out_ready_o;
  logic [7:0]      in_data_o;
  logic            in_valid_o;
  logic            in_ready_i;
  logic [8*WB-1:0] word_data_o;
  logic [6:0]      word_channel_o;
  logic            word_last_o;
  logic            word_valid_o;
  logic            word_ready_i;
  logic            config_active_o;

  wexp_t      wq[$];
  logic [7:0] sq[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         hold_ready = 1'b0;
  bit         exp_active = 1'b0;

  config_stream_deframer #(.WORD_BYTES(WB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
    .word_data_o(word_data_o), .word_channel_o(word_channel_o),
    .word_last_o(word_last_o), .word_valid_o(word_valid_o),
    .word_ready_i(word_ready_i), .config_active_o(config_active_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Random downstream/host readiness.
  initial begin
    word_ready_i = 1'b0;
    in_ready_i   = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      word_ready_i = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
      in_ready_i   = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops the scoreboard on every completed handshake.
  wexp_t mw;
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (word_valid_o && word_ready_i) begin
        if (wq.size() == 0) chk("unexpected word", {32'd0, word_data_o}, 64'hDEAD_0000_0000);
        else begin
          mw = wq.pop_front();
          chk("word data", 64'(word_data_o), 64'(mw.d));
          chk("word channel", 64'(word_channel_o), 64'(mw.ch));
          chk("word last", 64'(word_last_o), 64'(mw.last));
        end
      end
      if (in_valid_o && in_ready_i) begin
        if (sq.size() == 0) chk("unexpected status", 64'(in_data_o), 64'h1_0000);
        else chk("status byte", 64'(in_data_o), 64'(sq.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    out_data_i  = b;
    out_valid_i = 1'b1;
    for (int i = 0; i < 2000 && !acc; i++) begin
      @(negedge clk_i);
      acc = out_ready_o;
      @(posedge clk_i); #1;
    end
    out_valid_i = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL byte accept: byte %0h never accepted, required accept", b);
    end
  endtask

  task automatic send_q(input bq_t q);
    foreach (q[i]) begin
      send_byte(q[i]);
      repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    end
  endtask

  function automatic int find_sync(input bq_t q);
    for (int i = 0; i + 2 < q.size(); i++)
      if (q[i] == 8'h00 && q[i+1] == 8'hAA && q[i+2] == 8'hFF) return i;
    return -1;
  endfunction

  // Noise followed by sync, with no earlier sync hidden in the noise.
  function automatic bq_t make_hdr(input int noise);
    bq_t q;
    for (int t = 0; t < 20; t++) begin
      q = {};
      for (int i = 0; i < noise; i++) q.push_back(8'($urandom));
      q.push_back(8'h00); q.push_back(8'hAA); q.push_back(8'hFF);
      if (find_sync(q) == noise) return q;
    end
    q = {8'h00, 8'hAA, 8'hFF};
    return q;
  endfunction

  // Expected words from a payload of k bytes in a frame of nw words.
  task automatic push_words(input bq_t p, input int c, input int nw);
    wexp_t e;
    for (int w = 0; w < p.size() / WB; w++) begin
      e.d = '0;
      for (int j = 0; j < WB; j++) e.d = (e.d << 8) | (8*WB)'(p[w*WB + j]);
      e.ch   = 7'(c - 1);
      e.last = (w == nw - 1);
      wq.push_back(e);
    end
  endtask

  task automatic good_frame(input int c, input int n, input int noise);
    bq_t q, p;
    int  nw;
    nw = (n == 0) ? 256 : n;
    q  = make_hdr(noise);
    q.push_back(8'(c)); q.push_back(8'(n));
    for (int i = 0; i < nw * WB; i++) p.push_back(8'($urandom));
    push_words(p, c, nw);
    sq.push_back(8'hA5);
    exp_active = 1'b1;
    foreach (p[i]) q.push_back(p[i]);
    send_q(q);
  endtask

  task automatic wait_resp(output int k);
    k = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk_i);
      if (in_valid_o) begin k = i; break; end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic drain;
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk_i); #1;
      done = (wq.size() == 0) && (sq.size() == 0);
    end
    chk("drain words left", 64'(wq.size()), 64'd0);
    chk("drain status left", 64'(sq.size()), 64'd0);
    repeat (3) begin @(posedge clk_i); #1; end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, " out_ready"}, 64'(out_ready_o), 64'd0);
    chk({tag, " in_valid"}, 64'(in_valid_o), 64'd0);
    chk({tag, " in_data"}, 64'(in_data_o), 64'd0);
    chk({tag, " word_valid"}, 64'(word_valid_o), 64'd0);
    chk({tag, " word_data"}, 64'(word_data_o), 64'd0);
    chk({tag, " active"}, 64'(config_active_o), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t  q, p;
    int   k, c, n, kind;
    wexp_t e;

    repeat (3) begin @(posedge clk_i); #1; end
    check_zero_outputs("reset");
    reset_i = 1'b0;
    @(posedge clk_i); #1;

    // Directed good frame.
    q = {8'h00, 8'hAA, 8'hFF, 8'h01, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
         8'h01, 8'h23, 8'h45, 8'h67};
    e.d = 32'hDEADBEEF; e.ch = 7'd0; e.last = 1'b0; wq.push_back(e);
    e.d = 32'h01234567; e.ch = 7'd0; e.last = 1'b1; wq.push_back(e);
    sq.push_back(8'hA5);
    exp_active = 1'b1;
    send_q(q);
    drain();
    chk("active after good frame", 64'(config_active_o), 64'd1);

    // Bad command, then a good frame on channel 1.
    q = {8'h00, 8'hAA, 8'hFF, 8'h05};
    sq.push_back(8'hE1);
    send_q(q);
    good_frame(2, 1, 0);
    drain();

    // Leading noise with a partial overlap of the sync.
    q = {8'hAA, 8'h00, 8'hAA, 8'hFF, 8'h02, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    e.d = 32'h11223344; e.ch = 7'd1; e.last = 1'b1; wq.push_back(e);
    sq.push_back(8'hA5);
    send_q(q);
    drain();

    // Downstream stall: 3 words, ready held low.
    hold_ready = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    p = {};
    for (int i = 0; i < 3 * WB; i++) p.push_back(8'($urandom));
    push_words(p, 1, 3);
    sq.push_back(8'hA5);
    q = {8'h00, 8'hAA, 8'hFF, 8'h01, 8'h03};
    for (int i = 0; i < 7; i++) q.push_back(p[i]);
    send_q(q);
    out_data_i  = p[7];
    out_valid_i = 1'b1;
    repeat (5) begin @(posedge clk_i); #1; end
    @(negedge clk_i);
    chk("stall out_ready", 64'(out_ready_o), 64'd0);
    chk("stall word_valid", 64'(word_valid_o), 64'd1);
    @(posedge clk_i); #1;
    hold_ready = 1'b0;
    for (int i = 7; i < 3 * WB; i++) send_byte(p[i]);
    drain();

    // Directed timeout: len 1, two payload bytes, then silence.
    q = {8'h00, 8'hAA, 8'hFF, 8'h01, 8'h01, 8'h12, 8'h34};
    sq.push_back(8'hE2);
    send_q(q[0:4]);
    send_byte(q[5]);
    send_byte(q[6]);
    wait_resp(k);
    chk("timeout latency", 64'(k), 64'(TMO + 1));
    drain();

    // Mid-frame reset after two payload bytes.
    q = {8'h00, 8'hAA, 8'hFF, 8'h01, 8'h02, 8'h55, 8'h66};
    send_q(q);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    check_zero_outputs("midreset");
    reset_i = 1'b0;
    exp_active = 1'b0;
    good_frame(1, 2, 0);
    drain();

    // Random frames.
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 4);
      if (kind <= 1) begin
        good_frame($urandom_range(1, 2), $urandom_range(1, 4), $urandom_range(0, 3));
      end else if (kind == 2) begin
        q = make_hdr($urandom_range(0, 3));
        c = $urandom_range(0, 1) ? 0 : $urandom_range(3, 255);
        q.push_back(8'(c));
        sq.push_back(8'hE1);
        send_q(q);
      end else begin
        q = make_hdr($urandom_range(0, 2));
        k = $urandom_range(0, 2);
        if (k >= 1) begin
          c = $urandom_range(1, 2);
          q.push_back(8'(c));
          exp_active = 1'b1;
        end
        if (k == 2) begin
          n = $urandom_range(1, 3);
          q.push_back(8'(n));
          p = {};
          for (int i = 0; i < $urandom_range(0, n * WB - 1); i++) p.push_back(8'($urandom));
          push_words(p, c, n);
          foreach (p[i]) q.push_back(p[i]);
        end
        sq.push_back(8'hE2);
        send_q(q);
        wait_resp(k);
        if (k == 0) chk("random timeout reached", 64'(in_valid_o), 64'd1);
      end
    end
    drain();
    chk("final active", 64'(config_active_o), 64'(exp_active));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
